// File: rtl/inst_fetch_if.sv
// Fetch-unit bundle: redirect input, instruction-memory req/gnt/rvalid port,
// decoder valid/ready port, and read-only debug view of the internal counters.
interface inst_fetch_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              redirect;
  logic [DATA_W-1:0] redirect_pc;

  // imem: a transfer happens on imem_req & imem_gnt; once raised, req/addr hold
  // until granted unless redirect withdraws them; responses come back on
  // imem_rvalid strictly in grant order, at least one cycle after the grant.
  // decoder: an instruction moves on inst_valid & inst_ready; inst/inst_pc hold
  // while inst_valid & !inst_ready.
  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;

  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic [DATA_W-1:0] inst_pc;
  logic              inst_ready;

  logic [CW-1:0]     dbg_occ;
  logic [CW-1:0]     dbg_outstanding;
  logic [CW-1:0]     dbg_discard;

  modport master (
    input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    output dbg_occ, dbg_outstanding, dbg_discard
  );

  modport slave (
    output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  dbg_occ, dbg_outstanding, dbg_discard
  );
endinterface

// File: rtl/inst_fetch.sv
// ONC-16 instruction fetch front end: sequential PC, credit-limited imem reads,
// in-order prefetch queue to the decoder, redirect flush with stale-read discard.
module inst_fetch #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic          clock,
  input  logic          n_rst,
  inst_fetch_if.master  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = CW + 2;

  logic [DATA_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [DATA_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]     occ_q, occ_d;
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     disc_q, disc_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] word_q [DEPTH];
  logic [DATA_W-1:0] pc_q   [DEPTH];

  logic [SW-1:0] credit_used;
  logic          grant, live_rsp, drop_rsp, any_rsp, push, pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Queued, in-flight and stale reads all hold a credit, so a response can never find the queue full.
  assign credit_used   = SW'(occ_q) + SW'(out_q) + SW'(disc_q);
  assign bus.imem_req  = n_rst & ~bus.redirect & (credit_used < SW'(DEPTH));
  assign bus.imem_addr = fetch_addr_q;

  assign grant    = bus.imem_req & bus.imem_gnt;
  assign drop_rsp = bus.imem_rvalid & (disc_q != '0);
  assign live_rsp = bus.imem_rvalid & (disc_q == '0) & (out_q != '0);
  assign any_rsp  = bus.imem_rvalid & ((disc_q != '0) | (out_q != '0));
  assign push     = ~bus.redirect & live_rsp;
  assign pop      = ~bus.redirect & bus.inst_valid & bus.inst_ready;

  assign bus.inst_valid = (occ_q != '0);
  assign bus.inst       = word_q[rd_ptr_q];
  assign bus.inst_pc    = pc_q[rd_ptr_q];

  assign bus.dbg_occ         = occ_q;
  assign bus.dbg_outstanding = out_q;
  assign bus.dbg_discard     = disc_q;

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    resp_pc_d    = resp_pc_q;
    occ_d        = occ_q;
    out_d        = out_q;
    disc_d       = disc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    if (bus.redirect) begin
      // Every unanswered read becomes stale; a response arriving now is one of them.
      fetch_addr_d = bus.redirect_pc;
      resp_pc_d    = bus.redirect_pc;
      occ_d        = '0;
      out_d        = '0;
      disc_d       = CW'(SW'(disc_q) + SW'(out_q) - SW'(any_rsp));
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
    end else begin
      if (grant) fetch_addr_d = fetch_addr_q + DATA_W'(1);
      out_d  = out_q + CW'(grant) - CW'(live_rsp);
      disc_d = disc_q - CW'(drop_rsp);
      if (push) begin
        resp_pc_d = resp_pc_q + DATA_W'(1);
        wr_ptr_d  = next_ptr(wr_ptr_q);
      end
      if (pop) rd_ptr_d = next_ptr(rd_ptr_q);
      occ_d = occ_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      fetch_addr_q <= '0;
      resp_pc_q    <= '0;
      occ_q        <= '0;
      out_q        <= '0;
      disc_q       <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      fetch_addr_q <= fetch_addr_d;
      resp_pc_q    <= resp_pc_d;
      occ_q        <= occ_d;
      out_q        <= out_d;
      disc_q       <= disc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      if (push) begin
        word_q[wr_ptr_q] <= bus.imem_rdata;
        pc_q[wr_ptr_q]   <= resp_pc_q;
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: cycle table for streaming and grant stalls,
// hand-written sequences for backpressure, redirect and async reset.
module tb_inst_fetch;
  localparam int W     = 16;
  localparam int DEPTH = 3;

  logic clock = 1'b0;
  logic n_rst = 1'b0;
  always #5 clock = ~clock;

  inst_fetch_if #(.DATA_W(W), .DEPTH(DEPTH)) bus ();
  inst_fetch #(.DATA_W(W), .DEPTH(DEPTH)) dut (.clock(clock), .n_rst(n_rst), .bus(bus));

  typedef struct {
    logic         ready;
    logic         gnt;
    logic         exp_req;
    logic [W-1:0] exp_addr;
    logic         exp_valid;
    logic [W-1:0] exp_pc;
  } vec_t;

  int checks    = 0;
  int errors    = 0;
  int grant_cnt = 0;
  int pop_cnt   = 0;
  bit rsp_en    = 1'b0;
  bit sb_en     = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] pend_q[$];
  vec_t vecs[13];

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: record grants and decoder pops before the edge, then present the
  // memory response for the new cycle.
  task automatic tick();
    logic [W-1:0] e;
    #1;
    if (bus.imem_req && bus.imem_gnt) begin
      pend_q.push_back(bus.imem_addr);
      grant_cnt++;
    end
    if (sb_en && bus.inst_valid && bus.inst_ready && !bus.redirect) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got pc %h expected no instruction", bus.inst_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", bus.inst_pc, e);
        chk("sb_inst", bus.inst, mem_word(e));
      end
    end
    @(posedge clock);
    @(negedge clock);
    if (rsp_en && pend_q.size() > 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend_q.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end
  endtask

  task automatic do_reset();
    n_rst           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.inst_ready  = 1'b0;
    pend_q.delete();
    exp_q.delete();
    sb_en = 1'b0;
    repeat (2) @(negedge clock);
    n_rst = 1'b1;
  endtask

  task automatic fill_exp(input logic [W-1:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + W'(i));
  endtask

  task automatic run_pops(input int n, input int budget);
    for (int c = 0; c < budget && pop_cnt < n; c++) tick();
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 16'h0003, 1'b1, 16'h0001};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 16'h0005, 1'b1, 16'h0003};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 16'h0006, 1'b1, 16'h0004};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 16'h0006, 1'b1, 16'h0005};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 16'h0006, 1'b0, 16'h0000};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 16'h0006, 1'b0, 16'h0000};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 16'h0006, 1'b0, 16'h0000};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 16'h0007, 1'b0, 16'h0000};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 16'h0008, 1'b1, 16'h0006};

    // Reset values while n_rst is held low.
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.inst_ready  = 1'b1;
    @(negedge clock);
    #1;
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_addr", bus.imem_addr, 16'h0000);
    chk("rst_valid", bus.inst_valid, 1'b0);
    chk("rst_inst", bus.inst, 16'h0000);
    chk("rst_pc", bus.inst_pc, 16'h0000);

    // Streaming from reset, then four cycles of gnt=0 with req pending.
    do_reset();
    rsp_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      bus.inst_ready = vecs[i].ready;
      bus.imem_gnt   = vecs[i].gnt;
      #1;
      chk($sformatf("t1_req[%0d]", i), bus.imem_req, vecs[i].exp_req);
      chk($sformatf("t1_addr[%0d]", i), bus.imem_addr, vecs[i].exp_addr);
      chk($sformatf("t1_valid[%0d]", i), bus.inst_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        chk($sformatf("t1_pc[%0d]", i), bus.inst_pc, vecs[i].exp_pc);
        chk($sformatf("t1_inst[%0d]", i), bus.inst, mem_word(vecs[i].exp_pc));
      end
      tick();
    end

    // Decoder stalled: fetch stops at DEPTH credits, then drains in order.
    do_reset();
    rsp_en         = 1'b1;
    bus.imem_gnt   = 1'b1;
    bus.inst_ready = 1'b0;
    grant_cnt      = 0;
    repeat (8) tick();
    chk("t2_grants", grant_cnt, DEPTH);
    chk("t2_occ", bus.dbg_occ, DEPTH);
    chk("t2_req", bus.imem_req, 1'b0);
    chk("t2_valid", bus.inst_valid, 1'b1);
    chk("t2_head_pc", bus.inst_pc, 16'h0000);
    fill_exp(16'h0000, 10);
    sb_en          = 1'b1;
    pop_cnt        = 0;
    bus.inst_ready = 1'b1;
    run_pops(10, 60);
    chk("t2_pops", pop_cnt, 10);
    chk("t2_resumed", grant_cnt >= 10, 1'b1);

    // Redirect with two reads in flight: both responses must be dropped.
    do_reset();
    rsp_en         = 1'b0;
    bus.inst_ready = 1'b1;
    bus.imem_gnt   = 1'b1;
    tick();
    tick();
    bus.imem_gnt = 1'b0;
    chk("t4_outstanding", bus.dbg_outstanding, 2);
    chk("t4_addr_pre", bus.imem_addr, 16'h0002);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    #1;
    chk("t4_req_redirect", bus.imem_req, 1'b0);
    tick();
    bus.redirect = 1'b0;
    chk("t4_discard", bus.dbg_discard, 2);
    chk("t4_out_cleared", bus.dbg_outstanding, 0);
    chk("t4_valid", bus.inst_valid, 1'b0);
    chk("t4_addr_post", bus.imem_addr, 16'h0040);
    rsp_en       = 1'b1;
    bus.imem_gnt = 1'b1;
    fill_exp(16'h0040, 4);
    sb_en   = 1'b1;
    pop_cnt = 0;
    run_pops(4, 40);
    chk("t4_pops", pop_cnt, 4);
    chk("t4_discard_done", bus.dbg_discard, 0);

    // Redirect to 0xFFFF in the same cycle as an rvalid and a pop; PC wraps.
    do_reset();
    rsp_en         = 1'b1;
    bus.imem_gnt   = 1'b1;
    bus.inst_ready = 1'b1;
    fill_exp(16'h0000, 8);
    sb_en   = 1'b1;
    pop_cnt = 0;
    repeat (5) tick();
    chk("t5_pre_occ", bus.dbg_occ, 1);
    chk("t5_pre_out", bus.dbg_outstanding, 1);
    chk("t5_pre_rvalid", bus.imem_rvalid, 1'b1);
    chk("t5_pre_pops", pop_cnt, 3);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFF;
    tick();
    bus.redirect = 1'b0;
    chk("t5_valid", bus.inst_valid, 1'b0);
    chk("t5_occ", bus.dbg_occ, 0);
    chk("t5_out", bus.dbg_outstanding, 0);
    chk("t5_discard", bus.dbg_discard, 0);
    chk("t5_addr", bus.imem_addr, 16'hFFFF);
    exp_q.delete();
    fill_exp(16'hFFFF, 6);
    pop_cnt = 0;
    run_pops(4, 30);
    chk("t5_pops", pop_cnt, 4);

    // Asynchronous reset between edges while streaming.
    #2;
    n_rst = 1'b0;
    #1;
    chk("t6_req", bus.imem_req, 1'b0);
    chk("t6_addr", bus.imem_addr, 16'h0000);
    chk("t6_valid", bus.inst_valid, 1'b0);
    chk("t6_inst", bus.inst, 16'h0000);
    chk("t6_pc", bus.inst_pc, 16'h0000);
    chk("t6_occ", bus.dbg_occ, 0);
    sb_en = 1'b0;
    pend_q.delete();
    exp_q.delete();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    repeat (2) @(negedge clock);
    n_rst = 1'b1;
    fill_exp(16'h0000, 4);
    sb_en   = 1'b1;
    pop_cnt = 0;
    run_pops(4, 30);
    chk("t6_pops", pop_cnt, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
